// File: rtl/simd_pkg.sv
// Shared SIMD definitions used by the issue controller and the ALU.
// Contents: opcode enum, opcode width, datapath width, ALU latency and
// opcode classification helpers.
package simd_pkg;

  localparam int unsigned OpcodeWidth = 3;
  localparam int unsigned DataWidth   = 32;
  localparam int unsigned AluLatency  = 1;

  typedef enum logic [OpcodeWidth-1:0] {
    NOOP          = 3'd0,
    ADD           = 3'd1,
    SUB           = 3'd2,
    MUL           = 3'd3,
    DOTP          = 3'd4,
    STORE_TEMP_S1 = 3'd5,
    STORE_TEMP_S2 = 3'd6,
    STORE_RESULT  = 3'd7
  } opcode_e;

  // Opcodes that stream elements through the ALU.
  function automatic logic is_exec_op(logic [OpcodeWidth-1:0] op);
    return (op == ADD) || (op == SUB) || (op == MUL) || (op == DOTP);
  endfunction

  // Store opcodes are not legal for this controller and are flagged as errors.
  function automatic logic is_store_op(logic [OpcodeWidth-1:0] op);
    return (op == STORE_TEMP_S1) || (op == STORE_TEMP_S2) || (op == STORE_RESULT);
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Command handshake bundle for alu_issue_ctrl.
// Signals: cmd_valid (offer), cmd_ready (accept), cmd_opcode, cmd_len (element count).
// Modports: master drives the command, slave (the controller) returns cmd_ready.
interface alu_issue_ctrl_if #(
  parameter int unsigned OPCODE_WIDTH = 3,
  parameter int unsigned IDX_W        = 3
);

  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [OPCODE_WIDTH-1:0] cmd_opcode;
  logic [IDX_W:0]          cmd_len;

  modport master (
    output cmd_valid,
    output cmd_opcode,
    output cmd_len,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_opcode,
    input  cmd_len,
    output cmd_ready
  );

endinterface

// File: rtl/dotp_acc.sv
// Dot-product accumulator: cleared at command accept, adds one ALU product per capture.
// Ports: clk, rstn (async active-low), clear, add_en, add_val, acc_next (value the
// register takes at the next edge, used to write the final sum without an extra cycle).
// Build option: SIMD_DOTP_SAT_EN selects signed saturation to [-2^31, 2^31-1];
// without it the sum wraps modulo 2^32.
module dotp_acc
  import simd_pkg::*;
(
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 clear,
  input  logic                 add_en,
  input  logic [DataWidth-1:0] add_val,
  output logic [DataWidth-1:0] acc_next
);

  logic [DataWidth-1:0] acc_q;
  logic [DataWidth-1:0] sum;

`ifdef SIMD_DOTP_SAT_EN
  logic [DataWidth:0] sum_ext;

  always_comb begin
    sum_ext = {acc_q[DataWidth-1], acc_q} + {add_val[DataWidth-1], add_val};
    // Sign-extended carry disagreeing with the result sign means overflow.
    if (sum_ext[DataWidth] != sum_ext[DataWidth-1]) begin
      sum = sum_ext[DataWidth] ? {1'b1, {(DataWidth-1){1'b0}}} : {1'b0, {(DataWidth-1){1'b1}}};
    end else begin
      sum = sum_ext[DataWidth-1:0];
    end
  end
`else
  assign sum = acc_q + add_val;
`endif

  always_comb begin
    acc_next = acc_q;
    if (clear) begin
      acc_next = '0;
    end else if (add_en) begin
      acc_next = sum;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_next;
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Vector command issue controller for a 1-cycle-latency ALU.
// Accepts a command (opcode, length), streams elements 0..L-1 from the operand source
// into the ALU one per cycle, and writes results back (per element, or one DOTP sum).
// Ports: clk, rstn (async active-low); cmd (handshake interface, slave side);
// rd_idx/rd_a/rd_b (operand read); alu_opcode/alu_a/alu_b/alu_out (ALU);
// wr_en/wr_idx/wr_data (result write); busy, done, err (status pulses).
// Build option: SIMD_DOTP_SAT_EN (saturating DOTP accumulation, see dotp_acc).
module alu_issue_ctrl
  import simd_pkg::*;
#(
  parameter int unsigned OPCODE_WIDTH = simd_pkg::OpcodeWidth,
  parameter int unsigned VLEN         = 8,
  parameter int unsigned IDX_W        = $clog2(VLEN)
) (
  input  logic                    clk,
  input  logic                    rstn,
  alu_issue_ctrl_if.slave         cmd,
  output logic [IDX_W-1:0]        rd_idx,
  input  logic [DataWidth-1:0]    rd_a,
  input  logic [DataWidth-1:0]    rd_b,
  output logic [OPCODE_WIDTH-1:0] alu_opcode,
  output logic [DataWidth-1:0]    alu_a,
  output logic [DataWidth-1:0]    alu_b,
  input  logic [DataWidth-1:0]    alu_out,
  output logic                    wr_en,
  output logic [IDX_W-1:0]        wr_idx,
  output logic [DataWidth-1:0]    wr_data,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  localparam logic [IDX_W:0] VlenLen = (IDX_W+1)'(VLEN);

  state_e                  state_q;
  logic [OPCODE_WIDTH-1:0] op_q;
  logic [IDX_W:0]          len_q;
  logic [IDX_W-1:0]        idx_q;
  // Capture stage: an element was issued last cycle, its result is on alu_out now.
  logic                    cap_q;
  logic                    cap_last_q;
  logic [IDX_W-1:0]        cap_idx_q;
  logic                    wr_en_q;
  logic [IDX_W-1:0]        wr_idx_q;
  logic [DataWidth-1:0]    wr_data_q;
  logic                    done_q;
  logic                    err_q;

  logic                    handshake;
  logic [IDX_W:0]          eff_len;
  logic                    new_exec;
  logic                    new_store;
  logic                    is_dotp;
  logic                    issue_last;
  logic                    alu_active;
  logic [DataWidth-1:0]    acc_next;

  assign handshake  = cmd.cmd_valid && (state_q == StIdle);
  assign eff_len    = (cmd.cmd_len > VlenLen) ? VlenLen : cmd.cmd_len;
  assign new_exec   = is_exec_op(OpcodeWidth'(cmd.cmd_opcode));
  assign new_store  = is_store_op(OpcodeWidth'(cmd.cmd_opcode));
  assign is_dotp    = (op_q == OPCODE_WIDTH'(DOTP));
  assign issue_last = ({1'b0, idx_q} == (len_q - 1'b1));

  dotp_acc u_dotp_acc (
    .clk      (clk),
    .rstn     (rstn),
    .clear    (handshake),
    .add_en   (cap_q && is_dotp),
    .add_val  (alu_out),
    .acc_next (acc_next)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StIdle;
      op_q       <= OPCODE_WIDTH'(NOOP);
      len_q      <= '0;
      idx_q      <= '0;
      cap_q      <= 1'b0;
      cap_last_q <= 1'b0;
      cap_idx_q  <= '0;
      wr_en_q    <= 1'b0;
      wr_idx_q   <= '0;
      wr_data_q  <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      wr_en_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      cap_q      <= 1'b0;
      cap_last_q <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (cmd.cmd_valid) begin
            op_q  <= cmd.cmd_opcode;
            len_q <= eff_len;
            idx_q <= '0;
            if (new_exec && (eff_len != '0)) begin
              state_q <= StIssue;
            end else begin
              state_q <= StDone;
              done_q  <= 1'b1;
              err_q   <= new_store;
            end
          end
        end
        StIssue: begin
          cap_q      <= 1'b1;
          cap_idx_q  <= idx_q;
          cap_last_q <= issue_last;
          if (issue_last) begin
            state_q <= StDrain;
            idx_q   <= '0;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        StDrain: begin
          // Last capture has happened and its write is now presented.
          if (!cap_q) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase

      if (cap_q) begin
        if (is_dotp) begin
          if (cap_last_q) begin
            wr_en_q   <= 1'b1;
            wr_idx_q  <= '0;
            wr_data_q <= acc_next;
          end
        end else begin
          wr_en_q   <= 1'b1;
          wr_idx_q  <= cap_idx_q;
          wr_data_q <= alu_out;
        end
      end
    end
  end

  // The ALU output mux follows alu_opcode, so hold it through the last capture.
  assign alu_active = (state_q == StIssue) || cap_q;

  always_comb begin
    cmd.cmd_ready = (state_q == StIdle);
    busy          = (state_q != StIdle);
    rd_idx        = idx_q;
    alu_opcode    = alu_active ? op_q : OPCODE_WIDTH'(NOOP);
    alu_a         = (state_q == StIssue) ? rd_a : '0;
    alu_b         = (state_q == StIssue) ? rd_b : '0;
    wr_en         = wr_en_q;
    wr_idx        = wr_idx_q;
    wr_data       = wr_data_q;
    done          = done_q;
    err           = err_q;
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a 1-cycle ALU model and a write scoreboard.
module tb_alu_issue_ctrl;
  import simd_pkg::*;

  localparam int unsigned VLEN  = 8;
  localparam int unsigned IDX_W = 3;

  typedef struct {
    int          idx;
    logic [31:0] data;
    int          cyc;
  } wr_exp_t;

  logic              clk;
  logic              rstn;
  logic [IDX_W-1:0]  rd_idx;
  logic [31:0]       rd_a;
  logic [31:0]       rd_b;
  logic [2:0]        alu_opcode;
  logic [31:0]       alu_a;
  logic [31:0]       alu_b;
  logic [31:0]       alu_out;
  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [31:0]       wr_data;
  logic              busy;
  logic              done;
  logic              err;

  logic [31:0] mem_a [VLEN];
  logic [31:0] mem_b [VLEN];
  wr_exp_t     sb [$];
  int          n_checks;
  int          n_pass;

  alu_issue_ctrl_if #(.OPCODE_WIDTH(3), .IDX_W(IDX_W)) cmd_if ();

  alu_issue_ctrl #(.OPCODE_WIDTH(3), .VLEN(VLEN), .IDX_W(IDX_W)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .cmd        (cmd_if),
    .rd_idx     (rd_idx),
    .rd_a       (rd_a),
    .rd_b       (rd_b),
    .alu_opcode (alu_opcode),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_out    (alu_out),
    .wr_en      (wr_en),
    .wr_idx     (wr_idx),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rd_a = mem_a[rd_idx];
  assign rd_b = mem_b[rd_idx];

  function automatic logic [31:0] alu_ref(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    case (op)
      ADD:       return a + b;
      SUB:       return a - b;
      MUL, DOTP: return a * b;
      default:   return 32'd0;
    endcase
  endfunction

  // External ALU: result appears one cycle after the operands.
  always @(posedge clk) alu_out <= alu_ref(alu_opcode, alu_a, alu_b);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  task automatic push_expected(input logic [2:0] op, input int l);
    wr_exp_t e;
    longint  s;
    longint  p;
    if (!(op inside {ADD, SUB, MUL, DOTP}) || l == 0) return;
    if (op == DOTP) begin
      s = 0;
      for (int i = 0; i < l; i++) begin
        p = longint'($signed(alu_ref(op, mem_a[i], mem_b[i])));
        s = s + p;
`ifdef SIMD_DOTP_SAT_EN
        if (s > 64'sd2147483647) s = 64'sd2147483647;
        if (s < -64'sd2147483648) s = -64'sd2147483648;
`endif
      end
      e.idx  = 0;
      e.data = s[31:0];
      e.cyc  = l + 2;
      sb.push_back(e);
    end else begin
      for (int i = 0; i < l; i++) begin
        e.idx  = i;
        e.data = alu_ref(op, mem_a[i], mem_b[i]);
        e.cyc  = 3 + i;
        sb.push_back(e);
      end
    end
  endtask

  // Runs one command from handshake to done; after the handshake the command inputs
  // are replaced by post_* (used to hold the next command valid while busy).
  task automatic run_cmd(input string name, input logic [2:0] op, input int len,
                         input bit exp_err, input bit post_valid,
                         input logic [2:0] post_op, input int post_len);
    int      l;
    int      rel;
    int      exp_done;
    bit      got_done;
    bit      exec;
    wr_exp_t e;
    l        = (len > int'(VLEN)) ? int'(VLEN) : len;
    exec     = (op inside {ADD, SUB, MUL, DOTP}) && (l > 0);
    exp_done = exec ? l + 3 : 1;
    push_expected(op, l);
    @(posedge clk); #1;
    cmd_if.cmd_valid  = 1'b1;
    cmd_if.cmd_opcode = op;
    cmd_if.cmd_len    = 4'(len);
    @(negedge clk);
    chk({name, ".ready"}, cmd_if.cmd_ready, 1'b1);
    rel      = 0;
    got_done = 1'b0;
    while (!got_done && rel < 40) begin
      @(posedge clk); #1;
      rel++;
      if (rel == 1) begin
        cmd_if.cmd_valid  = post_valid;
        cmd_if.cmd_opcode = post_op;
        cmd_if.cmd_len    = 4'(post_len);
      end
      @(negedge clk);
      if (rel == 1) chk({name, ".busy"}, busy, 1'b1);
      if (exec && rel <= l) chk({name, ".rd_idx"}, 32'(rd_idx), rel - 1);
      if (wr_en) begin
        if (sb.size() == 0) begin
          chk({name, ".wr_unexpected"}, wr_en, 1'b0);
        end else begin
          e = sb.pop_front();
          chk({name, ".wr_idx"}, 32'(wr_idx), e.idx);
          chk({name, ".wr_data"}, wr_data, e.data);
          chk({name, ".wr_cycle"}, rel, e.cyc);
        end
      end
      if (done) begin
        got_done = 1'b1;
        chk({name, ".done_cycle"}, rel, exp_done);
        chk({name, ".err"}, err, exp_err);
        chk({name, ".alu_idle"}, {29'd0, alu_opcode}, 32'(NOOP));
      end
    end
    if (!got_done) chk({name, ".done_timeout"}, done, 1'b1);
    chk({name, ".sb_empty"}, sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    int stray;
    n_checks          = 0;
    n_pass            = 0;
    rstn              = 1'b0;
    cmd_if.cmd_valid  = 1'b0;
    cmd_if.cmd_opcode = NOOP;
    cmd_if.cmd_len    = '0;
    for (int i = 0; i < int'(VLEN); i++) begin
      mem_a[i] = 32'd0;
      mem_b[i] = 32'd0;
    end
    #12;
    chk("rst.ready", cmd_if.cmd_ready, 1'b1);
    chk("rst.busy", busy, 1'b0);
    chk("rst.wr_en", wr_en, 1'b0);
    chk("rst.done", done, 1'b0);
    chk("rst.err", err, 1'b0);
    chk("rst.wr_data", wr_data, 32'd0);
    chk("rst.alu_op", {29'd0, alu_opcode}, 32'(NOOP));
    @(negedge clk);
    rstn = 1'b1;

    // ADD L=4: {11,22,33,44} in cycles 3..6, done 7.
    for (int i = 0; i < 4; i++) begin
      mem_a[i] = 32'(i + 1);
      mem_b[i] = 32'(10 * (i + 1));
    end
    run_cmd("add4", ADD, 4, 1'b0, 1'b0, STORE_RESULT, 15);

    // DOTP L=3: 2*5+3*6+4*7 = 56 in cycle 5.
    mem_a[0] = 32'd2; mem_a[1] = 32'd3; mem_a[2] = 32'd4;
    mem_b[0] = 32'd5; mem_b[1] = 32'd6; mem_b[2] = 32'd7;
    run_cmd("dotp3", DOTP, 3, 1'b0, 1'b0, ADD, 1);

    // DOTP overflow: wraps or saturates depending on the build.
    mem_a[0] = 32'h7FFF_FFFF; mem_b[0] = 32'd1;
    mem_a[1] = 32'd1;         mem_b[1] = 32'd1;
    run_cmd("dotp_ovf", DOTP, 2, 1'b0, 1'b0, NOOP, 0);

    run_cmd("add_len0", ADD, 0, 1'b0, 1'b0, NOOP, 0);
    run_cmd("store_res", STORE_RESULT, 4, 1'b1, 1'b0, NOOP, 0);
    run_cmd("store_s1", STORE_TEMP_S1, 2, 1'b1, 1'b0, NOOP, 0);
    run_cmd("noop3", NOOP, 3, 1'b0, 1'b0, NOOP, 0);

    // SUB len=12 clipped to 8, second command held valid while busy.
    for (int i = 0; i < int'(VLEN); i++) begin
      mem_a[i] = 32'(100 + 7 * i);
      mem_b[i] = 32'(3 * i + 1);
    end
    run_cmd("sub12_a", SUB, 12, 1'b0, 1'b1, SUB, 12);
    run_cmd("sub12_b", SUB, 12, 1'b0, 1'b0, NOOP, 0);

    // MUL L=8 aborted by reset in cycle 4.
    for (int i = 0; i < int'(VLEN); i++) begin
      mem_a[i] = 32'(i + 2);
      mem_b[i] = 32'(i + 5);
    end
    @(posedge clk); #1;
    cmd_if.cmd_valid  = 1'b1;
    cmd_if.cmd_opcode = MUL;
    cmd_if.cmd_len    = 4'd8;
    @(posedge clk); #1;
    cmd_if.cmd_valid  = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk); #1;
    chk("mul_rst.busy_before", busy, 1'b1);
    rstn = 1'b0;
    #1;
    chk("mul_rst.ready", cmd_if.cmd_ready, 1'b1);
    chk("mul_rst.busy", busy, 1'b0);
    chk("mul_rst.wr_en", wr_en, 1'b0);
    chk("mul_rst.wr_idx", 32'(wr_idx), 0);
    chk("mul_rst.rd_idx", 32'(rd_idx), 0);
    chk("mul_rst.wr_data", wr_data, 32'd0);
    chk("mul_rst.alu_op", {29'd0, alu_opcode}, 32'(NOOP));
    chk("mul_rst.alu_a", alu_a, 32'd0);
    chk("mul_rst.alu_b", alu_b, 32'd0);
    chk("mul_rst.done_err", {30'd0, done, err}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rstn  = 1'b1;
    stray = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (wr_en) stray++;
    end
    chk("mul_rst.no_wr_after", stray, 0);

    // New command after reset release.
    mem_a[0] = 32'd9; mem_b[0] = 32'd8;
    mem_a[1] = 32'd5; mem_b[1] = 32'd6;
    run_cmd("mul_after_rst", MUL, 2, 1'b0, 1'b0, NOOP, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 SHALL have parameter OPCODE_WIDTH, default 3, ALU opcode width.
REQ-002 SHALL have parameter VLEN, default 8, maximum elements per vector command.
REQ-003 SHALL have parameter IDX_W, default $clog2(VLEN), element index width.
REQ-004 SHALL have ports: clk input 1 clock; rstn input 1 reset. One clock; reset asynchronous, active-low.
REQ-005 SHALL have ports: cmd_valid input 1 command offered; cmd_ready output 1 command accepted when both high; cmd_opcode input OPCODE_WIDTH operation; cmd_len input IDX_W+1 element count.
REQ-006 SHALL have ports: rd_idx output IDX_W operand element index; rd_a input 32 operand A at rd_idx (combinational source); rd_b input 32 operand B at rd_idx.
REQ-007 SHALL have ports: alu_opcode output OPCODE_WIDTH; alu_a output 32; alu_b output 32; alu_out input 32 ALU result, one cycle after operands.
REQ-008 SHALL have ports: wr_en output 1 result write strobe; wr_idx output IDX_W result index; wr_data output 32 result.
REQ-009 SHALL have ports: busy output 1 command in progress; done output 1 single-cycle completion pulse; err output 1 single-cycle illegal-opcode pulse.

Function
REQ-010 SHALL implement states IDLE, ISSUE, DRAIN, DONE; cmd_ready=1 only in IDLE; busy=1 in ISSUE, DRAIN, DONE.
REQ-011 SHALL on handshake (cycle 0) latch opcode and effective length L=min(cmd_len,VLEN); go to ISSUE if L>0 and opcode in {ADD,SUB,MUL,DOTP}, else to DONE.
REQ-012 SHALL in ISSUE drive element i (0..L-1) in cycle 1+i: rd_idx=i, alu_a=rd_a, alu_b=rd_b; go to DRAIN after element L-1.
REQ-013 SHALL hold alu_opcode at the latched opcode from cycle 1 until the last alu_out capture (ALU output mux is opcode-selected); alu_opcode=NOOP, alu_a=alu_b=0 otherwise.
REQ-014 SHALL capture alu_out in cycle 2+i; for ADD/SUB/MUL register wr_en=1, wr_idx=i, wr_data=alu_out visible in cycle 3+i.
REQ-015 SHALL for DOTP clear accumulator at handshake, add alu_out each capture cycle, and issue exactly one write wr_idx=0, wr_data=final sum in cycle L+2.
REQ-016 SHALL leave DRAIN after the final write is presented, enter DONE for exactly one cycle with done=1, then return to IDLE.
REQ-017 SHALL for NOOP or L=0: no ALU activity, no writes, done pulse in cycle 1.
REQ-018 SHALL for STORE_TEMP_S1/S2/STORE_RESULT: no writes, err=1 and done=1 together in cycle 1.
REQ-019 SHALL ignore cmd_valid while busy; cmd_opcode/cmd_len changes after handshake have no effect.
REQ-020 SHALL keep wr_en=0 except on cycles defined by REQ-014/REQ-015; exactly L writes (element ops) or 1 write (DOTP) per command.
REQ-021 SHALL accept a new command in the cycle after DONE (back-to-back).

Reset
REQ-022 SHALL on rstn=0, asynchronously and at any state including mid-command: state=IDLE, cmd_ready=1, busy=done=err=wr_en=0, wr_idx=rd_idx=0, wr_data=0, alu_opcode=NOOP, alu_a=alu_b=0, accumulator=0; in-flight command discarded, no further writes.

Configuration
REQ-023 SHALL with SIMD_DOTP_SAT_EN defined: DOTP accumulation is signed-saturating to [-2^31, 2^31-1].
REQ-024 SHALL without SIMD_DOTP_SAT_EN: DOTP accumulation wraps modulo 2^32; all else identical.

Structure
REQ-025 SHALL take opcode enum (NOOP, ADD, SUB, MUL, DOTP, STORE_TEMP_S1, STORE_TEMP_S2, STORE_RESULT), OPCODE_WIDTH, data width 32 and ALU latency 1 from shared package simd_pkg, shared with the ALU.
REQ-026 SHALL place the DOTP accumulator (clear, add, saturate option) in sub-module dotp_acc.

Verification
REQ-027 ADD, L=4, A={1,2,3,4}, B={10,20,30,40}, ALU model 1-cycle -> writes idx0..3 = {11,22,33,44} in cycles 3..6, done cycle 7.
REQ-028 DOTP, L=3, A={2,3,4}, B={5,6,7} -> single write idx0=56 in cycle 5, done cycle 6, no other wr_en.
REQ-029 DOTP, L=2, products 0x7FFFFFFF and 1 -> SIMD_DOTP_SAT_EN: 0x7FFFFFFF; without: 0x80000000.
REQ-030 cmd_len=0 ADD, then STORE_RESULT L=4 -> done cycle 1, no writes; then err+done cycle 1, no writes.
REQ-031 MUL L=8, rstn low in cycle 4 -> all outputs at reset values immediately, no wr_en after, new command accepted after release.
REQ-032 cmd_len=12 (>VLEN) SUB back-to-back with second command held valid -> 8 writes, second accepted cycle after done.
